// File: rtl/exec_alu.sv
// Y86-64 execute stage: operand selection, ALU, condition-code register and branch/cmov condition.
// Build macro ALU_OR_EN adds bitwise OR as OP function 4.
module exec_alu #(
  parameter int DATA_WID = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic [DATA_WID-1:0] valA,
  input  logic [DATA_WID-1:0] valB,
  input  logic [DATA_WID-1:0] valC,
  output logic [DATA_WID-1:0] valE,
  output logic [3:0]          cc,
  output logic                cnd
);

  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OP     = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;
  localparam logic [3:0] F_OR  = 4'h4;

  localparam int MSB = DATA_WID - 1;

`ifdef ALU_OR_EN
  localparam bit OR_EN = 1'b1;
`else
  localparam bit OR_EN = 1'b0;
`endif

  localparam logic [DATA_WID-1:0] STACK_DEC = {{(DATA_WID-4){1'b1}}, 4'b1000};
  localparam logic [DATA_WID-1:0] STACK_INC = DATA_WID'(8);

  logic [DATA_WID-1:0] alu_a;
  logic [DATA_WID-1:0] alu_b;
  logic [DATA_WID-1:0] alu_res;
  logic [3:0]          fun_sel;
  logic                fun_ok;
  logic                of_flag;
  logic                zf_flag;
  logic                sf_flag;
  logic [3:0]          cc_reg;
  logic [3:0]          cc_next;
  logic                cc_we;

  always_comb begin
    alu_a = '0;
    case (icode)
      I_CMOVXX, I_OP:             alu_a = valA;
      I_IRMOV, I_RMMOV, I_MRMOV:  alu_a = valC;
      I_CALL, I_PUSH:             alu_a = STACK_DEC;
      I_RET, I_POP:               alu_a = STACK_INC;
      default:                    alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (icode)
      I_RMMOV, I_MRMOV, I_OP, I_CALL, I_PUSH, I_RET, I_POP: alu_b = valB;
      default:                                              alu_b = '0;
    endcase
  end

  assign fun_sel = (icode == I_OP) ? ifun : F_ADD;

  // Overflow is judged on operand signs versus result sign (two's complement rules).
  always_comb begin
    alu_res = '0;
    fun_ok  = 1'b1;
    of_flag = 1'b0;
    case (fun_sel)
      F_ADD: begin
        alu_res = alu_b + alu_a;
        of_flag = (alu_a[MSB] == alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
      end
      F_SUB: begin
        alu_res = alu_b - alu_a;
        of_flag = (alu_a[MSB] != alu_b[MSB]) && (alu_res[MSB] != alu_b[MSB]);
      end
      F_AND: alu_res = alu_b & alu_a;
      F_XOR: alu_res = alu_b ^ alu_a;
      F_OR: begin
        if (OR_EN) alu_res = alu_b | alu_a;
        else       fun_ok  = 1'b0;
      end
      default: fun_ok = 1'b0;
    endcase
  end

  assign zf_flag = (alu_res == '0);
  assign sf_flag = alu_res[MSB];
  assign cc_next = {1'b0, of_flag, sf_flag, zf_flag};
  assign cc_we   = (icode == I_OP) && fun_ok;
  assign valE    = alu_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_reg <= 4'b0001;
    end else if (cc_we) begin
      cc_reg <= cc_next;
    end
  end

  assign cc = cc_reg;

  // Condition uses stored flags, i.e. those of the previous OP instruction.
  always_comb begin
    cnd = 1'b0;
    if (icode == I_CMOVXX || icode == I_JXX) begin
      case (ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (cc_reg[1] ^ cc_reg[2]) | cc_reg[0];
        4'h2:    cnd = cc_reg[1] ^ cc_reg[2];
        4'h3:    cnd = cc_reg[0];
        4'h4:    cnd = ~cc_reg[0];
        4'h5:    cnd = ~(cc_reg[1] ^ cc_reg[2]);
        4'h6:    cnd = ~(cc_reg[1] ^ cc_reg[2]) & ~cc_reg[0];
        default: cnd = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_alu.sv
// Randomized and directed bench for exec_alu, compared against a signed-arithmetic reference model.
module tb_exec_alu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [63:0] valE;
  logic [3:0]  cc;
  logic        cnd;

  int          checks;
  int          failures;
  int          txn;
  logic [3:0]  model_cc;
  logic [63:0] last_valE;
  logic        last_cnd;
  logic [3:0]  last_cc;

  exec_alu #(.DATA_WID(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icode (icode),
    .ifun  (ifun),
    .valA  (valA),
    .valB  (valB),
    .valC  (valC),
    .valE  (valE),
    .cc    (cc),
    .cnd   (cnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: operands from the instruction table, results from 65-bit signed arithmetic.
  function automatic void ref_model(
    input  logic [3:0]  ic,
    input  logic [3:0]  fn,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] c,
    input  logic [3:0]  cc_in,
    output logic [63:0] ve,
    output logic        cn,
    output logic        wr,
    output logic [3:0]  cc_out
  );
    logic [63:0]        opa;
    logic [63:0]        opb;
    logic signed [64:0] full;
    logic               ovf;
    int                 f;
    logic               zf, sf, of;
    opa = 64'd0;
    opb = 64'd0;
    case (ic)
      4'h2, 4'h6:       opa = a;
      4'h3, 4'h4, 4'h5: opa = c;
      4'h8, 4'hA:       opa = -64'sd8;
      4'h9, 4'hB:       opa = 64'd8;
      default:          opa = 64'd0;
    endcase
    if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) opb = b;
    f   = (ic == 4'h6) ? int'(fn) : 0;
    ovf = 1'b0;
    wr  = (ic == 4'h6);
    ve  = 64'd0;
    case (f)
      0: begin
        full = $signed({opb[63], opb}) + $signed({opa[63], opa});
        ve   = full[63:0];
        ovf  = (full > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (full < -65'sh0_8000_0000_0000_0000);
      end
      1: begin
        full = $signed({opb[63], opb}) - $signed({opa[63], opa});
        ve   = full[63:0];
        ovf  = (full > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (full < -65'sh0_8000_0000_0000_0000);
      end
      2: ve = opb & opa;
      3: ve = opb ^ opa;
`ifdef ALU_OR_EN
      4: ve = opb | opa;
`endif
      default: begin
        ve = 64'd0;
        wr = 1'b0;
      end
    endcase
    cc_out = wr ? {1'b0, ovf, ve[63], (ve == 64'd0)} : cc_in;
    zf = cc_in[0];
    sf = cc_in[1];
    of = cc_in[2];
    cn = 1'b0;
    if (ic == 4'h2 || ic == 4'h7) begin
      case (fn)
        4'h0: cn = 1'b1;
        4'h1: cn = (sf != of) || zf;
        4'h2: cn = (sf != of);
        4'h3: cn = zf;
        4'h4: cn = !zf;
        4'h5: cn = (sf == of);
        4'h6: cn = (sf == of) && !zf;
        default: cn = 1'b0;
      endcase
    end
  endfunction

  // Drive one instruction just after a rising edge, check combinational outputs, then clock it.
  task automatic apply(input logic rn, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic [63:0] exp_ve;
    logic        exp_cn;
    logic        exp_wr;
    logic [3:0]  exp_cc;
    rst_n = rn;
    icode = ic;
    ifun  = fn;
    valA  = a;
    valB  = b;
    valC  = c;
    ref_model(ic, fn, a, b, c, model_cc, exp_ve, exp_cn, exp_wr, exp_cc);
    #2;
    last_valE = valE;
    last_cnd  = cnd;
    check("valE", valE, exp_ve);
    check("cnd", {63'd0, cnd}, {63'd0, exp_cn});
    @(posedge clk);
    model_cc = rn ? exp_cc : 4'b0001;
    #1;
    last_cc = cc;
    check("cc", {60'd0, cc}, {60'd0, model_cc});
    $display("txn %0d rst_n=%0b icode=%h ifun=%h valA=%h valB=%h valC=%h valE=%h cnd=%0b cc=%b",
             txn, rn, ic, fn, a, b, c, last_valE, last_cnd, last_cc);
    txn++;
  endtask

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    checks    = 0;
    failures  = 0;
    txn       = 0;
    model_cc  = 4'b0001;
    rst_n     = 1'b0;
    icode     = 4'h1;
    ifun      = 4'h0;
    valA      = 64'd0;
    valB      = 64'd0;
    valC      = 64'd0;
    @(posedge clk);
    #1;
    check("reset_cc", {60'd0, cc}, 64'd1);

    apply(1'b1, 4'h6, 4'h0, 64'd3, 64'd5, 64'd0);
    check("plan_add_valE", last_valE, 64'd8);
    check("plan_add_cc", {60'd0, last_cc}, 64'd0);
    apply(1'b1, 4'h6, 4'h1, 64'd4, 64'd10, 64'd0);
    check("plan_sub_valE", last_valE, 64'd6);
    apply(1'b1, 4'h6, 4'h1, 64'd10, 64'd4, 64'd0);
    check("plan_sub_neg_valE", last_valE, 64'hFFFF_FFFF_FFFF_FFFA);
    check("plan_sub_neg_cc", {60'd0, last_cc}, 64'b0010);
    apply(1'b1, 4'h6, 4'h2, 64'd1, 64'd2, 64'd0);
    check("plan_and_cc", {60'd0, last_cc}, 64'b0001);
    apply(1'b1, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    check("plan_add_ovf_cc", {60'd0, last_cc}, 64'b0110);
    apply(1'b1, 4'hA, 4'h0, 64'd0, 64'd64, 64'd0);
    check("plan_push_valE", last_valE, 64'd56);
    apply(1'b1, 4'hB, 4'h0, 64'd0, 64'd32, 64'd0);
    check("plan_pop_valE", last_valE, 64'd40);
    apply(1'b1, 4'h3, 4'h0, 64'd1, 64'd2, 64'd16);
    check("plan_irmov_valE", last_valE, 64'd16);
    check("plan_stack_cc_held", {60'd0, last_cc}, 64'b0110);
    apply(1'b1, 4'h6, 4'h4, 64'h0F, 64'hF0, 64'd0);
`ifndef ALU_OR_EN
    check("plan_op4_unsup_valE", last_valE, 64'd0);
`endif
    apply(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
    apply(1'b1, 4'h2, 4'h3, 64'd2, 64'd9, 64'd0);
    check("plan_cmove_valE", last_valE, 64'd2);
    check("plan_cmove_cnd", {63'd0, last_cnd}, 64'd1);
    apply(1'b1, 4'h2, 4'h2, 64'd4, 64'd9, 64'd0);
    check("plan_cmovl_cnd", {63'd0, last_cnd}, 64'd0);
    apply(1'b1, 4'h7, 4'h0, 64'd0, 64'd0, 64'd0);
    check("plan_jmp_cnd", {63'd0, last_cnd}, 64'd1);
    apply(1'b1, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    check("plan_jge_cnd", {63'd0, last_cnd}, 64'd1);
    apply(1'b1, 4'h6, 4'h1, 64'd10, 64'd4, 64'd0);
    apply(1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
    check("plan_reset_cc", {60'd0, last_cc}, 64'b0001);
    apply(1'b0, 4'h6, 4'h1, 64'd10, 64'd4, 64'd0);
    check("plan_reset_hold_cc", {60'd0, last_cc}, 64'b0001);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] ic;
      logic       rn;
      ic = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      rn = ($urandom_range(0, 15) != 0);
      apply(rn, ic, 4'($urandom_range(0, 7)), rand_val(), rand_val(), rand_val());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
